// File: rtl/mux_nto1_pipe.sv
// Registered N-to-1 selector feeding a 2-entry FIFO with valid/ready on both sides.
// A lock mode pins the select captured on the first locked accept.
module mux_nto1_pipe #(
  parameter int WIDTH = 5,
  parameter int SEL_W = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [(2**SEL_W)*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]            sel,
  input  logic                        lock,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [SEL_W-1:0]            out_sel,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        locked
);

  typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

  lock_state_t      state;
  logic [SEL_W-1:0] lock_sel;
  logic [SEL_W-1:0] eff_sel;
  logic [WIDTH-1:0] new_data;
  logic [WIDTH-1:0] d0, d1;
  logic [SEL_W-1:0] s0, s1;
  logic [1:0]       count;
  logic             accept, pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = d0;
  assign out_sel   = s0;
  assign locked    = (state == LOCKED);

  // Dropping lock takes effect on the same edge, so that transfer uses sel.
  always_comb begin
    eff_sel  = (state == LOCKED && lock) ? lock_sel : sel;
    new_data = in_bus[eff_sel*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= UNLOCKED;
      lock_sel <= '0;
    end else if (!lock) begin
      state <= UNLOCKED;
    end else if (state == UNLOCKED && accept) begin
      state    <= LOCKED;
      lock_sel <= sel;
    end
  end

  // d0 is the head; it is only overwritten when a new head exists, so an
  // emptied buffer keeps presenting the last popped entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d0    <= '0;
      d1    <= '0;
      s0    <= '0;
      s1    <= '0;
      count <= '0;
    end else begin
      case ({accept, pop})
        2'b10: begin
          if (count == 2'd0) begin
            d0 <= new_data;
            s0 <= eff_sel;
          end else begin
            d1 <= new_data;
            s1 <= eff_sel;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) begin
            d0 <= d1;
            s0 <= s1;
          end
          count <= count - 2'd1;
        end
        2'b11: begin
          d0 <= new_data;
          s0 <= eff_sel;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Bench for mux_nto1_pipe: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mux_nto1_pipe;
  localparam int WIDTH = 5;
  localparam int SEL_W = 2;
  localparam int N     = 2**SEL_W;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [N*WIDTH-1:0]   in_bus = '0;
  logic [SEL_W-1:0]     sel = '0;
  logic                 lock = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [WIDTH-1:0]     out_data;
  logic [SEL_W-1:0]     out_sel;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic                 locked;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  mux_nto1_pipe #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .sel(sel), .lock(lock),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready),
    .locked(locked)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of {data, sel} entries plus the lock flag.
  logic [WIDTH+SEL_W-1:0] q[$];
  logic [WIDTH+SEL_W-1:0] last_head = '0;
  logic [WIDTH+SEL_W-1:0] m_ent;
  bit                     m_locked = 1'b0;
  int                     m_lsel = 0;
  int                     m_eff;
  bit                     m_acc, m_pop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      last_head = '0;
      m_locked  = 1'b0;
      m_lsel    = 0;
    end else begin
      m_acc = in_valid && (q.size() < 2);
      m_pop = out_ready && (q.size() > 0);
      m_eff = (m_locked && lock) ? m_lsel : int'(sel);
      if (m_pop) last_head = q.pop_front();
      if (m_acc) begin
        m_ent = {in_bus[m_eff*WIDTH +: WIDTH], SEL_W'(m_eff)};
        q.push_back(m_ent);
      end
      if (!lock) m_locked = 1'b0;
      else if (m_acc && !m_locked) begin
        m_locked = 1'b1;
        m_lsel   = int'(sel);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  logic [WIDTH+SEL_W-1:0] exp_head;
  always @(negedge clk) begin
    if (cmp_en) begin
      exp_head = (q.size() > 0) ? q[0] : last_head;
      chk("m_out_valid", int'(out_valid), int'(q.size() > 0));
      chk("m_in_ready",  int'(in_ready),  int'(q.size() < 2));
      chk("m_locked",    int'(locked),    int'(m_locked));
      chk("m_out_data",  int'(out_data),  int'(exp_head[WIDTH+SEL_W-1:SEL_W]));
      chk("m_out_sel",   int'(out_sel),   int'(exp_head[SEL_W-1:0]));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int s);
    in_valid = 1'b1;
    sel      = SEL_W'(s);
  endtask

  task automatic mid_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data",  int'(out_data),  0);
    chk("rst_out_sel",   int'(out_sel),   0);
    chk("rst_locked",    int'(locked),    0);
    chk("rst_in_ready",  int'(in_ready),  1);
    #3 rst_n = 1'b1;
  endtask

  initial begin
    #12;
    chk("init_out_valid", int'(out_valid), 0);
    chk("init_in_ready",  int'(in_ready),  1);
    chk("init_out_data",  int'(out_data),  0);
    chk("init_locked",    int'(locked),    0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    cyc();

    // single transfer: channels {31,17,9,3}, sel=2 -> 17
    in_bus = {5'd31, 5'd17, 5'd9, 5'd3};
    out_ready = 1'b1;
    push(2);
    cyc();
    chk("t1_valid", int'(out_valid), 1);
    chk("t1_data",  int'(out_data), 17);
    chk("t1_sel",   int'(out_sel), 2);
    in_valid = 1'b0;
    cyc();
    chk("t1_drained", int'(out_valid), 0);
    chk("t1_hold",    int'(out_data), 17);

    // back-pressure fill
    out_ready = 1'b0;
    push(0); cyc();
    push(3); cyc();
    chk("bp_in_ready_full", int'(in_ready), 0);
    push(1); cyc();
    chk("bp_still_full", int'(in_ready), 0);
    chk("bp_head0", int'(out_data), 3);
    in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    chk("bp_head1", int'(out_data), 31);
    chk("bp_in_ready_after_pop", int'(in_ready), 1);
    cyc();
    chk("bp_empty", int'(out_valid), 0);

    // push+pop at count=1, then 4 back-to-back
    out_ready = 1'b0;
    push(1); cyc();
    out_ready = 1'b1;
    push(2); cyc();
    chk("pp_head", int'(out_data), 17);
    chk("pp_count1", int'(in_ready), 1);
    for (int i = 0; i < 4; i++) begin
      push(i); cyc();
      chk("b2b_valid", int'(out_valid), 1);
      chk("b2b_sel", int'(out_sel), i);
    end
    in_valid = 1'b0; cyc();
    chk("b2b_empty", int'(out_valid), 0);

    // lock
    lock = 1'b1;
    push(1); cyc();
    chk("lk_locked0", int'(locked), 1);
    chk("lk_sel0", int'(out_sel), 1);
    chk("lk_data0", int'(out_data), 9);
    push(0); cyc();
    chk("lk_sel1", int'(out_sel), 1);
    push(3); cyc();
    chk("lk_sel2", int'(out_sel), 1);
    chk("lk_locked2", int'(locked), 1);
    lock = 1'b0;
    push(3); cyc();
    chk("ul_sel", int'(out_sel), 3);
    chk("ul_data", int'(out_data), 31);
    chk("ul_locked", int'(locked), 0);
    in_valid = 1'b0; cyc();

    // async reset while full and locked
    lock = 1'b1; out_ready = 1'b0;
    push(2); cyc();
    push(0); cyc();
    in_valid = 1'b0;
    chk("ar_full", int'(in_ready), 0);
    chk("ar_locked", int'(locked), 1);
    mid_reset();
    lock = 1'b0; out_ready = 1'b1;
    cyc();
    chk("ar_no_stale_valid", int'(out_valid), 0);
    chk("ar_no_stale_data", int'(out_data), 0);
    cyc();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      in_bus    = N*WIDTH'({$urandom, $urandom});
      sel       = SEL_W'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      lock      = ($urandom_range(0, 4) > 1);
      if (i == 300) mid_reset();
      cyc();
    end

    in_valid = 1'b0;
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
